hazard_scoreboard: RTL and testbench

//  Parametrised D-stage hazard unit for the pipelined core.
//  - Shadows the write-back info (dest, Tnew) of every stage after D.
//  - Compares it against the Tuse of each D-stage source to raise stall and

---
 rtl/hazard_scoreboard_if.sv | 39 +++
 rtl/hazard_scoreboard.sv | 124 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Purpose : D-stage hazard bundle between the decode stage (master) and the
//           hazard scoreboard (slave).
// Signals : tue_d   source i is read by the D instruction
//           tu_d    Tuse of source i, slice [i*TW +: TW]
//           ra_d    address of source i, slice [i*AW +: AW]
//           rwe_d   D instruction writes a register
//           rwa_d   D destination address
//           tn_d    D Tnew on entering stage 1
//           md_op_d 00 none, 01 mult, 10 div, 11 HI/LO access
//           stall   hold F/D, bubble into E
//           fwd_sel per source: 0 = regfile, k = stage k result
//           md_busy mult/div unit busy
interface hazard_scoreboard_if #(
    parameter int NSRC = 2,
    parameter int AW   = 5,
    parameter int TW   = 2,
    parameter int SW   = 2
);
    logic [NSRC-1:0]    tue_d;
    logic [NSRC*TW-1:0] tu_d;
    logic [NSRC*AW-1:0] ra_d;
    logic               rwe_d;
    logic [AW-1:0]      rwa_d;
    logic [TW-1:0]      tn_d;
    logic [1:0]         md_op_d;
    logic               stall;
    logic [NSRC*SW-1:0] fwd_sel;
    logic               md_busy;

    modport master (
        output tue_d, tu_d, ra_d, rwe_d, rwa_d, tn_d, md_op_d,
        input  stall, fwd_sel, md_busy
    );

    modport slave (
        input  tue_d, tu_d, ra_d, rwe_d, rwa_d, tn_d, md_op_d,
        output stall, fwd_sel, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Purpose : D-stage hazard unit. Shadows dest/Tnew of every stage after D,
//           compares against the Tuse of each D source to raise stall and
//           select a forwarding source, and owns the mult/div busy counter.
// Ports   : clk   rising-edge clock
//           reset asynchronous, active-high
//           hz    hazard_scoreboard_if.slave (D-stage inputs, stall/fwd/busy)
module hazard_scoreboard #(
    parameter int NSRC    = 2,
    parameter int NSTG    = 3,
    parameter int AW      = 5,
    parameter int TW      = 2,
    parameter int SW      = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CW      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_scoreboard_if.slave   hz
);

    // Shadow of each tracked stage: valid writer, its dest, its remaining Tnew
    logic          r_v [1:NSTG];
    logic [AW-1:0] r_a [1:NSTG];
    logic [TW-1:0] r_t [1:NSTG];
    logic [CW-1:0] r_cnt;

    logic [NSRC-1:0]    w_src_stall;
    logic [NSRC*SW-1:0] w_fwd_sel;
    logic               w_md_stall;
    logic               w_stall;

    // Per-source hit search. The chain runs from the oldest stage towards
    // stage 1 so the youngest matching writer ends up selected.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            logic [AW-1:0] w_ra;
            logic [TW-1:0] w_tu;
            logic          w_en;
            logic          w_hit_c [1:NSTG+1];
            logic [SW-1:0] w_h_c   [1:NSTG+1];
            logic [TW-1:0] w_t_c   [1:NSTG+1];
            logic          w_hit;

            assign w_ra = hz.ra_d[gi*AW +: AW];
            assign w_tu = hz.tu_d[gi*TW +: TW];
            assign w_en = hz.tue_d[gi] && (w_ra != '0);

            assign w_hit_c[NSTG+1] = 1'b0;
            assign w_h_c[NSTG+1]   = '0;
            assign w_t_c[NSTG+1]   = '0;

            for (gj = 1; gj <= NSTG; gj++) begin : g_stg
                logic w_match;
                assign w_match     = r_v[gj] && (r_a[gj] == w_ra);
                assign w_hit_c[gj] = w_match || w_hit_c[gj+1];
                assign w_h_c[gj]   = w_match ? SW'(gj) : w_h_c[gj+1];
                assign w_t_c[gj]   = w_match ? r_t[gj] : w_t_c[gj+1];
            end

            assign w_hit = w_en && w_hit_c[1];
            assign w_src_stall[gi] = w_hit && (w_tu < w_t_c[1]);
            // Forward only once the producer's result exists (Tnew reached 0)
            assign w_fwd_sel[gi*SW +: SW] = (w_hit && (w_t_c[1] == '0)) ? w_h_c[1] : '0;
        end
    endgenerate

    assign w_md_stall = (hz.md_op_d != 2'b00) && (r_cnt != '0);
    assign w_stall    = (|w_src_stall) || w_md_stall;

    assign hz.stall   = w_stall;
    assign hz.fwd_sel = w_fwd_sel;
    assign hz.md_busy = (r_cnt != '0);

    // Stage 1 takes the D instruction, or a bubble while D is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v[1] <= 1'b0;
            r_a[1] <= '0;
            r_t[1] <= '0;
        end else if (w_stall) begin
            r_v[1] <= 1'b0;
            r_a[1] <= '0;
            r_t[1] <= '0;
        end else begin
            r_v[1] <= hz.rwe_d && (hz.rwa_d != '0);
            r_a[1] <= hz.rwa_d;
            r_t[1] <= hz.tn_d;
        end
    end

    // Older stages shift unconditionally; Tnew counts down to 0 and holds
    generate
        for (gi = 2; gi <= NSTG; gi++) begin : g_shift
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_v[gi] <= 1'b0;
                    r_a[gi] <= '0;
                    r_t[gi] <= '0;
                end else begin
                    r_v[gi] <= r_v[gi-1];
                    r_a[gi] <= r_a[gi-1];
                    r_t[gi] <= (r_t[gi-1] == '0) ? '0 : r_t[gi-1] - TW'(1);
                end
            end
        end
    endgenerate

    // A start can only issue when not stalled, and md_stall blocks any start
    // while busy, so a load never collides with a decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!w_stall && (hz.md_op_d == 2'b01)) begin
            r_cnt <= CW'(MUL_LAT);
        end else if (!w_stall && (hz.md_op_d == 2'b10)) begin
            r_cnt <= CW'(DIV_LAT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic clk;
    logic reset;

    hazard_scoreboard_if #(.NSRC(2), .AW(5), .TW(2), .SW(2)) hz ();

    hazard_scoreboard #(
        .NSRC(2), .NSTG(3), .AW(5), .TW(2), .SW(2),
        .MUL_LAT(5), .DIV_LAT(10), .CW(4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       s;
        logic [3:0] f;
        logic       b;
    } exp_t;

    exp_t  sb_q [$];
    int    n_cmp = 0;
    int    n_err = 0;
    string cur_test = "init";

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s.%s observed=%0h expected=%0h", cur_test, tag, obs, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val("stall", {31'd0, hz.stall}, {31'd0, e.s});
            check_val("fwd_sel", {28'd0, hz.fwd_sel}, {28'd0, e.f});
            check_val("md_busy", {31'd0, hz.md_busy}, {31'd0, e.b});
            $display("[%0t] %s stall=%0b fwd_sel=%h md_busy=%0b", $time, cur_test,
                     hz.stall, hz.fwd_sel, hz.md_busy);
        end
    endtask

    // One D-stage cycle: drive after the edge, push expectation, check at negedge
    task automatic step(input logic [1:0] tue, input logic [3:0] tu, input logic [9:0] ra,
                        input logic rwe, input logic [4:0] rwa, input logic [1:0] tn,
                        input logic [1:0] md, input logic es, input logic [3:0] ef,
                        input logic eb);
        exp_t e;
        @(posedge clk);
        #1;
        hz.tue_d   = tue;
        hz.tu_d    = tu;
        hz.ra_d    = ra;
        hz.rwe_d   = rwe;
        hz.rwa_d   = rwa;
        hz.tn_d    = tn;
        hz.md_op_d = md;
        e.s = es; e.f = ef; e.b = eb;
        sb_q.push_back(e);
        @(negedge clk);
        compare_out();
    endtask

    task automatic nop(input logic es, input logic eb);
        step(2'b00, 4'h0, 10'd0, 1'b0, 5'd0, 2'd0, 2'b00, es, 4'h0, eb);
    endtask

    initial begin
        exp_t e;
        reset      = 1'b1;
        hz.tue_d   = '0;
        hz.tu_d    = '0;
        hz.ra_d    = '0;
        hz.rwe_d   = 1'b0;
        hz.rwa_d   = '0;
        hz.tn_d    = '0;
        hz.md_op_d = '0;

        cur_test = "reset";
        nop(1'b0, 1'b0);
        nop(1'b0, 1'b0);
        reset = 1'b0;
        nop(1'b0, 1'b0);

        // lw $2 (tn=2); addu $5 reads $2 (tu=0)
        cur_test = "lw_use";
        step(2'b00, 4'h0, 10'd0, 1'b1, 5'd2, 2'd2, 2'b00, 1'b0, 4'h0, 1'b0);
        step(2'b01, 4'h0, {5'd0, 5'd2}, 1'b1, 5'd5, 2'd1, 2'b00, 1'b1, 4'h0, 1'b0);
        step(2'b01, 4'h0, {5'd0, 5'd2}, 1'b1, 5'd5, 2'd1, 2'b00, 1'b1, 4'h0, 1'b0);
        step(2'b01, 4'h0, {5'd0, 5'd2}, 1'b1, 5'd5, 2'd1, 2'b00, 1'b0, 4'h3, 1'b0);
        repeat (3) nop(1'b0, 1'b0);

        // addu $3 (tn=1); beq reads $3 (tu=0)
        cur_test = "alu_branch";
        step(2'b00, 4'h0, 10'd0, 1'b1, 5'd3, 2'd1, 2'b00, 1'b0, 4'h0, 1'b0);
        step(2'b01, 4'h0, {5'd0, 5'd3}, 1'b0, 5'd0, 2'd0, 2'b00, 1'b1, 4'h0, 1'b0);
        step(2'b01, 4'h0, {5'd0, 5'd3}, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0, 4'h2, 1'b0);
        repeat (3) nop(1'b0, 1'b0);

        // lw $0 never creates a hazard
        cur_test = "reg_zero";
        step(2'b00, 4'h0, 10'd0, 1'b1, 5'd0, 2'd2, 2'b00, 1'b0, 4'h0, 1'b0);
        step(2'b11, 4'h0, 10'd0, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0, 4'h0, 1'b0);
        step(2'b11, 4'h0, 10'd0, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0, 4'h0, 1'b0);
        repeat (2) nop(1'b0, 1'b0);

        // ori $4, addu $4, reader tu=1: youngest writer shadows the older one
        cur_test = "shadow";
        step(2'b00, 4'h0, 10'd0, 1'b1, 5'd4, 2'd1, 2'b00, 1'b0, 4'h0, 1'b0);
        step(2'b00, 4'h0, 10'd0, 1'b1, 5'd4, 2'd1, 2'b00, 1'b0, 4'h0, 1'b0);
        step(2'b01, 4'h1, {5'd0, 5'd4}, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0, 4'h0, 1'b0);
        repeat (3) nop(1'b0, 1'b0);

        // Both sources hit the same stage; tue masks source 1
        cur_test = "two_src";
        step(2'b00, 4'h0, 10'd0, 1'b1, 5'd7, 2'd1, 2'b00, 1'b0, 4'h0, 1'b0);
        nop(1'b0, 1'b0);
        step(2'b11, 4'h0, {5'd7, 5'd7}, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0, 4'ha, 1'b0);
        step(2'b01, 4'h0, {5'd7, 5'd7}, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0, 4'h3, 1'b0);
        repeat (3) nop(1'b0, 1'b0);

        // mult then mfhi: 5 stall cycles
        cur_test = "mult_mfhi";
        step(2'b00, 4'h0, 10'd0, 1'b0, 5'd0, 2'd0, 2'b01, 1'b0, 4'h0, 1'b0);
        repeat (5) step(2'b00, 4'h0, 10'd0, 1'b0, 5'd0, 2'd0, 2'b11, 1'b1, 4'h0, 1'b1);
        step(2'b00, 4'h0, 10'd0, 1'b0, 5'd0, 2'd0, 2'b11, 1'b0, 4'h0, 1'b0);

        // div then mult: 10 stall cycles, then mult busy 5 cycles
        cur_test = "div_mult";
        step(2'b00, 4'h0, 10'd0, 1'b0, 5'd0, 2'd0, 2'b10, 1'b0, 4'h0, 1'b0);
        repeat (10) step(2'b00, 4'h0, 10'd0, 1'b0, 5'd0, 2'd0, 2'b01, 1'b1, 4'h0, 1'b1);
        step(2'b00, 4'h0, 10'd0, 1'b0, 5'd0, 2'd0, 2'b01, 1'b0, 4'h0, 1'b0);
        repeat (5) nop(1'b0, 1'b1);
        nop(1'b0, 1'b0);

        // Source stall and md_stall together
        cur_test = "combo";
        step(2'b00, 4'h0, 10'd0, 1'b1, 5'd8, 2'd2, 2'b01, 1'b0, 4'h0, 1'b0);
        step(2'b01, 4'h0, {5'd0, 5'd8}, 1'b0, 5'd0, 2'd0, 2'b11, 1'b1, 4'h0, 1'b1);
        step(2'b01, 4'h0, {5'd0, 5'd8}, 1'b0, 5'd0, 2'd0, 2'b11, 1'b1, 4'h0, 1'b1);
        step(2'b01, 4'h0, {5'd0, 5'd8}, 1'b0, 5'd0, 2'd0, 2'b11, 1'b1, 4'h3, 1'b1);
        step(2'b01, 4'h0, {5'd0, 5'd8}, 1'b0, 5'd0, 2'd0, 2'b11, 1'b1, 4'h0, 1'b1);
        step(2'b01, 4'h0, {5'd0, 5'd8}, 1'b0, 5'd0, 2'd0, 2'b11, 1'b1, 4'h0, 1'b1);
        step(2'b01, 4'h0, {5'd0, 5'd8}, 1'b0, 5'd0, 2'd0, 2'b11, 1'b0, 4'h0, 1'b0);
        nop(1'b0, 1'b0);

        // div busy with a pending writer, then asynchronous reset mid-cycle
        cur_test = "reset_mid";
        step(2'b00, 4'h0, 10'd0, 1'b0, 5'd0, 2'd0, 2'b10, 1'b0, 4'h0, 1'b0);
        nop(1'b0, 1'b1);
        nop(1'b0, 1'b1);
        step(2'b00, 4'h0, 10'd0, 1'b1, 5'd9, 2'd2, 2'b00, 1'b0, 4'h0, 1'b1);
        step(2'b01, 4'h0, {5'd0, 5'd9}, 1'b0, 5'd0, 2'd0, 2'b11, 1'b1, 4'h0, 1'b1);
        reset = 1'b1;
        #1;
        e.s = 1'b0; e.f = 4'h0; e.b = 1'b0;
        sb_q.push_back(e);
        compare_out();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(2'b01, 4'h0, {5'd0, 5'd9}, 1'b0, 5'd0, 2'd0, 2'b11, 1'b0, 4'h0, 1'b0);

        cur_test = "end";
        check_val("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
